// File: rtl/dram_file_port_ctrl_if.sv
// rtl/dram_file_port_ctrl_if.sv - command, stream and DRAM file-port bundle for the file port controller
interface dram_file_port_ctrl_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic              start_load;
    logic              start_dump;
    logic              abort;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] word_count;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              done;
    logic              err;
    logic [DATA_W-1:0] dram_dataIn;
    logic [ADDR_W-1:0] dram_addr;
    logic              dram_we;
    logic [DATA_W-1:0] dram_dataOut;

    // Host and DRAM side: issues commands, feeds/drains streams, models the memory
    modport master (
        output start_load, start_dump, abort, base_addr, word_count,
        output in_data, in_valid, out_ready, dram_dataOut,
        input  in_ready, out_data, out_valid, busy, done, err,
        input  dram_dataIn, dram_addr, dram_we
    );

    modport slave (
        input  start_load, start_dump, abort, base_addr, word_count,
        input  in_data, in_valid, out_ready, dram_dataOut,
        output in_ready, out_data, out_valid, busy, done, err,
        output dram_dataIn, dram_addr, dram_we
    );
endinterface

// File: rtl/dram_file_port_ctrl.sv
// rtl/dram_file_port_ctrl.sv - sequential LOAD/DUMP controller on the DRAM external file port
module dram_file_port_ctrl #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 51
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dram_file_port_ctrl_if.slave bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_DUMP = 2'd2;
    localparam logic [1:0] ST_FIN  = 2'd3;

    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] remaining_q, remaining_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [ADDR_W:0]   end_addr;
    logic              range_ok;
    logic              beat;

    // One extra bit so base+count cannot wrap into a falsely legal range
    assign end_addr = {1'b0, bus.base_addr} + {1'b0, bus.word_count};
    assign range_ok = (bus.word_count != '0) && (end_addr <= DEPTH_X);
    assign beat     = ((state_q == ST_LOAD) && bus.in_valid) ||
                      ((state_q == ST_DUMP) && bus.out_ready);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        remaining_d = remaining_q;
        err_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start_load && bus.start_dump) begin
                    err_d = 1'b1;
                end else if (bus.start_load || bus.start_dump) begin
                    if (range_ok) begin
                        ptr_d       = bus.base_addr;
                        remaining_d = bus.word_count;
                        state_d     = bus.start_load ? ST_LOAD : ST_DUMP;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_LOAD, ST_DUMP: begin
                if (beat) begin
                    ptr_d       = ptr_q + ADDR_W'(1);
                    remaining_d = remaining_q - ADDR_W'(1);
                    if (remaining_q == ADDR_W'(1)) state_d = ST_FIN;
                end
                // Abort wins over a final beat: the write still commits but no done
                if (bus.abort) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        done_d = (state_d == ST_FIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            remaining_q <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            remaining_q <= remaining_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign bus.in_ready    = (state_q == ST_LOAD);
    assign bus.dram_we     = bus.in_ready & bus.in_valid;
    assign bus.dram_addr   = ptr_q;
    assign bus.dram_dataIn = (state_q == ST_LOAD) ? bus.in_data : '0;
    assign bus.out_valid   = (state_q == ST_DUMP);
    assign bus.out_data    = (state_q == ST_DUMP) ? bus.dram_dataOut : '0;
    assign bus.busy        = (state_q == ST_LOAD) || (state_q == ST_DUMP);
    assign bus.done        = done_q;
    assign bus.err         = err_q;
endmodule
